// File: rtl/alu_if.sv
// Operand/result bundle for alu_topmodule: operation select and operands in, registered result and flag out.
interface alu_if #(
  parameter int W = 8
) ();
  logic [2:0]   ALUOp;
  logic [W-1:0] R2;
  logic [W-1:0] R3;
  logic [W-1:0] R0;
  logic         c_out;

  modport master (output ALUOp, output R2, output R3, input R0, input c_out);
  modport slave  (input ALUOp, input R2, input R3, output R0, output c_out);
endinterface

// File: rtl/alu_topmodule.sv
// Single-cycle ALU: result computed combinationally from ALUOp/R2/R3 and registered,
// giving exactly one cycle of latency. Outputs clear asynchronously on reset.
module alu_topmodule #(
  parameter int W = 8
) (
  input  logic clk,
  input  logic rst_n,
  alu_if.slave bus
);

  typedef enum logic [2:0] {
    OP_MOV = 3'b000,
    OP_NOT = 3'b001,
    OP_ADD = 3'b010,
    OP_SUB = 3'b011,
    OP_OR  = 3'b100,
    OP_AND = 3'b101,
    OP_SLT = 3'b110,
    OP_RSV = 3'b111
  } alu_op_t;

  alu_op_t      op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] nxt_r;
  logic         nxt_c;
  logic [W-1:0] r_q;
  logic         c_q;

  assign op = alu_op_t'(bus.ALUOp);
  assign a  = bus.R2;
  assign b  = bus.R3;

  always_comb begin
    nxt_r = '0;
    nxt_c = 1'b0;
    unique case (op)
      OP_MOV: nxt_r = a;
      OP_NOT: nxt_r = ~a;
      OP_ADD: {nxt_c, nxt_r} = {1'b0, a} + {1'b0, b};
      // carry out of A + ~B + 1 is the inverted borrow
      OP_SUB: {nxt_c, nxt_r} = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, 1'b1};
      OP_OR:  nxt_r = a | b;
      OP_AND: nxt_r = a & b;
      OP_SLT: nxt_r = {{(W-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_RSV: nxt_r = '0;
      default: nxt_r = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
      c_q <= 1'b0;
    end else begin
      r_q <= nxt_r;
      c_q <= nxt_c;
    end
  end

  assign bus.R0    = r_q;
  assign bus.c_out = c_q;

endmodule

// File: tb/tb_alu_topmodule.sv
// Scoreboarded bench for alu_topmodule: driver pushes reference results, monitor pops
// and compares one cycle later; directed vectors, random traffic and async reset.
module tb_alu_topmodule;
  localparam int    W   = 8;
  localparam longint MOD = longint'(1) << W;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  alu_if #(.W(W)) bus ();

  alu_topmodule #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] r;
    logic         c;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  // Reference model: plain integer arithmetic on the operation definitions.
  function automatic exp_t verification_alu(logic [2:0] op, logic [W-1:0] a, logic [W-1:0] b);
    exp_t   e;
    longint ua = longint'(a);
    longint ub = longint'(b);
    longint sa = (ua >= MOD / 2) ? ua - MOD : ua;
    longint sb_v = (ub >= MOD / 2) ? ub - MOD : ub;
    longint res = 0;
    bit     c = 0;
    case (op)
      3'd0: res = ua;
      3'd1: res = MOD - 1 - ua;
      3'd2: begin res = (ua + ub) % MOD; c = (ua + ub) >= MOD; end
      3'd3: begin res = (ua - ub + MOD) % MOD; c = (ua >= ub); end
      3'd4: res = longint'(a | b);
      3'd5: res = longint'(a & b);
      3'd6: res = (sa < sb_v) ? 1 : 0;
      default: res = 0;
    endcase
    e.op = op; e.a = a; e.b = b;
    e.r  = res[W-1:0];
    e.c  = c;
    return e;
  endfunction

  task automatic check(string name, longint act, longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Monitor: result for the inputs captured at a rising edge is checked just after it.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check($sformatf("R0 op=%0d R2=%02h R3=%02h", e.op, e.a, e.b), longint'(bus.R0), longint'(e.r));
      check($sformatf("c_out op=%0d R2=%02h R3=%02h", e.op, e.a, e.b), longint'(bus.c_out), longint'(e.c));
    end
  end

  task automatic issue(logic [2:0] op, logic [W-1:0] a, logic [W-1:0] b);
    @(negedge clk);
    bus.ALUOp = op;
    bus.R2    = a;
    bus.R3    = b;
    sb.push_back(verification_alu(op, a, b));
  endtask

  localparam int ND = 17;
  logic [2:0]   d_op [ND] = '{3'd6, 3'd6, 3'd6, 3'd6, 3'd6, 3'd6, 3'd2, 3'd2, 3'd3, 3'd3, 3'd3,
                              3'd0, 3'd1, 3'd4, 3'd5, 3'd7, 3'd2};
  logic [W-1:0] d_a  [ND] = '{8'hFA, 8'h3A, 8'h00, 8'h00, 8'hFA, 8'h3A, 8'hFA, 8'h01, 8'hFA, 8'h3A, 8'h55,
                              8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hFF};
  logic [W-1:0] d_b  [ND] = '{8'h3A, 8'hFA, 8'hFA, 8'h3A, 8'h00, 8'h00, 8'h3A, 8'h02, 8'h3A, 8'hFA, 8'h55,
                              8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'h01};
  // Hand-derived results for the table above.
  logic [W-1:0] d_r  [ND] = '{8'h01, 8'h00, 8'h00, 8'h01, 8'h01, 8'h00, 8'h34, 8'h03, 8'hC0, 8'h40, 8'h00,
                              8'hF0, 8'h0F, 8'hFC, 8'h30, 8'h00, 8'h00};
  logic         d_c  [ND] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1,
                              1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    exp_t e;
    bus.ALUOp = 3'd2;
    bus.R2    = 8'hFA;
    bus.R3    = 8'h3A;

    // Reset holds outputs low across clock edges.
    #22;
    check("reset R0", longint'(bus.R0), 0);
    check("reset c_out", longint'(bus.c_out), 0);

    // First edge after release registers the present inputs.
    @(negedge clk);
    rst_n = 1'b1;
    sb.push_back(verification_alu(bus.ALUOp, bus.R2, bus.R3));

    // Directed vectors: confirm model against fixed values, then scoreboard the DUT.
    for (int i = 0; i < ND; i++) begin
      e = verification_alu(d_op[i], d_a[i], d_b[i]);
      check($sformatf("model r vec%0d", i), longint'(e.r), longint'(d_r[i]));
      check($sformatf("model c vec%0d", i), longint'(e.c), longint'(d_c[i]));
      issue(d_op[i], d_a[i], d_b[i]);
    end

    // Input change between edges must not reach the outputs.
    issue(3'd2, 8'hFA, 8'h3A);
    @(posedge clk);
    #2;
    bus.ALUOp = 3'd1;
    bus.R2    = 8'h00;
    #1;
    check("no comb path R0", longint'(bus.R0), 'h34);
    check("no comb path c_out", longint'(bus.c_out), 1);

    // Mid-stream asynchronous reset.
    issue(3'd2, 8'hFA, 8'h3A);
    @(posedge clk);
    #2;
    check("pre-reset R0", longint'(bus.R0), 'h34);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("async reset R0", longint'(bus.R0), 0);
    check("async reset c_out", longint'(bus.c_out), 0);
    #1;
    rst_n = 1'b1;
    sb.push_back(verification_alu(bus.ALUOp, bus.R2, bus.R3));
    @(posedge clk);
    #2;
    check("post-reset R0", longint'(bus.R0), 'h34);
    check("post-reset c_out", longint'(bus.c_out), 1);

    // Random traffic, back-to-back every cycle.
    for (int i = 0; i < 400; i++)
      issue(3'($urandom_range(0, 7)), W'($urandom), W'($urandom));

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #3;
    check("scoreboard drained", longint'(sb.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
